// File: rtl/lc3_mem_ctrl.sv
`timescale 1ns/1ps
// LC-3 memory access controller: owns MAR/MDR, sequences the single-port RAM
// and serves the KBSR/KBDR/DSR/DDR device registers on the I/O page.
module lc3_mem_ctrl #(
  parameter int unsigned TIMEOUT = 8,
  parameter logic [15:0] IO_BASE = 16'hFE00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] BUS_IN,
  input  logic        MAR_LD,
  input  logic        MDR_LD,
  input  logic        MEM_EN,
  input  logic        RW,
  output logic [15:0] MDR_OUT,
  output logic        R,
  output logic        ERR,
  output logic [15:0] RAM_ADDR,
  output logic [15:0] RAM_DIN,
  output logic        RAM_CS,
  output logic        RAM_WE,
  input  logic [15:0] RAM_DOUT,
  input  logic        RAM_READY,
  input  logic [7:0]  KB_DATA,
  input  logic        KB_STROBE,
  output logic [7:0]  DISP_DATA,
  output logic        DISP_STROBE,
  input  logic        DISP_ACK
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] KBSR_A = IO_BASE;
  localparam logic [DW-1:0] KBDR_A = IO_BASE + 16'd2;
  localparam logic [DW-1:0] DSR_A  = IO_BASE + 16'd4;
  localparam logic [DW-1:0] DDR_A  = IO_BASE + 16'd6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    IO_RD   = 3'd4,
    IO_WR   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   mar, mar_n;
  logic [DW-1:0]   mdr, mdr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            kbrdy, kbrdy_n;
  logic [CW-1:0]   kb_reg, kb_reg_n;
  logic            drdy, drdy_n;
  logic [CW-1:0]   disp_data, disp_data_n;
  logic            err_n, dstb_n;
  logic            r_q, err_q, cs_q, we_q, dstb_q;
  logic            is_io;

  assign is_io = (mar >= IO_BASE);

  // State, datapath registers and registered handshake outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      cnt       <= '0;
      kbrdy     <= 1'b0;
      kb_reg    <= '0;
      drdy      <= 1'b1;
      disp_data <= '0;
      r_q       <= 1'b0;
      err_q     <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      dstb_q    <= 1'b0;
    end else begin
      state     <= state_n;
      mar       <= mar_n;
      mdr       <= mdr_n;
      cnt       <= cnt_n;
      kbrdy     <= kbrdy_n;
      kb_reg    <= kb_reg_n;
      drdy      <= drdy_n;
      disp_data <= disp_data_n;
      r_q       <= (state_n == DONE);
      err_q     <= err_n;
      cs_q      <= (state_n == RD_REQ) || (state_n == WR_REQ);
      we_q      <= (state_n == WR_REQ);
      dstb_q    <= dstb_n;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_n     = state;
    mar_n       = mar;
    mdr_n       = mdr;
    cnt_n       = cnt;
    kbrdy_n     = kbrdy;
    kb_reg_n    = kb_reg;
    drdy_n      = drdy;
    disp_data_n = disp_data;
    err_n       = 1'b0;
    dstb_n      = 1'b0;

    // Device-side events are accepted in any state; FSM actions below may override
    if (KB_STROBE) begin
      kb_reg_n = KB_DATA;
      kbrdy_n  = 1'b1;
    end
    if (DISP_ACK) begin
      drdy_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (MAR_LD) mar_n = BUS_IN;
        if (MDR_LD) mdr_n = BUS_IN;
        if (MEM_EN) begin
          if (RW) state_n = is_io ? IO_WR : WR_REQ;
          else    state_n = is_io ? IO_RD : RD_REQ;
        end
      end
      RD_REQ: begin
        cnt_n   = '0;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (RAM_READY) begin
          mdr_n   = RAM_DOUT;
          state_n = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          mdr_n   = '0;
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WR_REQ: begin
        state_n = DONE;
      end
      IO_RD: begin
        if (mar == KBSR_A) begin
          mdr_n = {kbrdy, 15'b0};
        end else if (mar == KBDR_A) begin
          mdr_n = {8'h00, kb_reg};
          // A strobe landing on this read keeps the fresh character flagged
          if (!KB_STROBE) kbrdy_n = 1'b0;
        end else if (mar == DSR_A) begin
          mdr_n = {drdy, 15'b0};
        end else begin
          mdr_n = '0;
        end
        state_n = DONE;
      end
      IO_WR: begin
        if ((mar == DDR_A) && drdy) begin
          disp_data_n = mdr[CW-1:0];
          dstb_n      = 1'b1;
          drdy_n      = 1'b0;
        end
        state_n = DONE;
      end
      DONE: begin
        if (!MEM_EN) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign MDR_OUT     = mdr;
  assign RAM_ADDR    = mar;
  assign RAM_DIN     = mdr;
  assign R           = r_q;
  assign ERR         = err_q;
  assign RAM_CS      = cs_q;
  assign RAM_WE      = we_q;
  assign DISP_DATA   = disp_data;
  assign DISP_STROBE = dstb_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for lc3_mem_ctrl: vector table of accesses against a small RAM model,
// expected read-back queued at issue and compared when R rises.
module tb_lc3_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] BUS_IN;
  logic        MAR_LD, MDR_LD, MEM_EN, RW;
  logic [15:0] MDR_OUT;
  logic        R, ERR;
  logic [15:0] RAM_ADDR, RAM_DIN;
  logic        RAM_CS, RAM_WE;
  logic [15:0] RAM_DOUT;
  logic        ram_rdy_m;
  logic        stale_ready;
  logic [7:0]  KB_DATA;
  logic        KB_STROBE;
  logic [7:0]  DISP_DATA;
  logic        DISP_STROBE;
  logic        DISP_ACK;

  always #5 CLK = ~CLK;

  lc3_mem_ctrl #(.TIMEOUT(8), .IO_BASE(16'hFE00)) dut (
    .CLK(CLK), .RST(RST), .BUS_IN(BUS_IN), .MAR_LD(MAR_LD), .MDR_LD(MDR_LD),
    .MEM_EN(MEM_EN), .RW(RW), .MDR_OUT(MDR_OUT), .R(R), .ERR(ERR),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_CS(RAM_CS), .RAM_WE(RAM_WE),
    .RAM_DOUT(RAM_DOUT), .RAM_READY(ram_rdy_m | stale_ready),
    .KB_DATA(KB_DATA), .KB_STROBE(KB_STROBE), .DISP_DATA(DISP_DATA),
    .DISP_STROBE(DISP_STROBE), .DISP_ACK(DISP_ACK)
  );

  // RAM model: data and READY follow a CS read after ram_lat extra cycles
  logic [15:0] mem [256];
  int  ram_lat  = 0;
  bit  ram_dead = 1'b0;
  int  pend     = 0;
  int  cyc      = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  end

  always @(posedge CLK) begin
    cyc       <= cyc + 1;
    ram_rdy_m <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1 && !ram_dead) ram_rdy_m <= 1'b1;
    end
    if (RAM_CS && RAM_WE) mem[RAM_ADDR[7:0]] <= RAM_DIN;
    if (RAM_CS && !RAM_WE) begin
      RAM_DOUT <= mem[RAM_ADDR[7:0]];
      if (ram_lat == 0) ram_rdy_m <= !ram_dead;
      else              pend      <= ram_lat;
    end
  end

  // Activity counters sampled mid-cycle
  int cs_total = 0, we_total = 0, stb_total = 0, err_total = 0;
  logic [15:0] cs_addr = 16'h0, cs_din = 16'h0;
  always @(negedge CLK) begin
    if (RAM_CS) begin
      cs_total <= cs_total + 1;
      cs_addr  <= RAM_ADDR;
      cs_din   <= RAM_DIN;
      if (RAM_WE) we_total <= we_total + 1;
    end
    if (DISP_STROBE) stb_total <= stb_total + 1;
    if (ERR) err_total <= err_total + 1;
  end

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [15:0] wdata;
    int          ram_lat;
    bit          dead;
    bit          stale;
    int          kb_pre;
    int          kb_mid;
    bit          ack_pre;
    bit          ack_mid;
    logic [15:0] exp_mdr;
    logic        exp_err;
    int          exp_lat;
    int          exp_cs;
    int          exp_stb;
  } vec_t;

  typedef struct {
    logic [15:0] mdr;
    logic        err;
    int          lat;
    int          start;
  } sb_t;

  sb_t  sb[$];
  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] disp_exp = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] addr, input logic rw, input logic [15:0] wdata,
                              input logic [15:0] exp_mdr, input int exp_lat, input int exp_cs);
    vec_t v;
    v.addr = addr;  v.rw = rw;  v.wdata = wdata;
    v.ram_lat = 0;  v.dead = 1'b0;  v.stale = 1'b0;
    v.kb_pre = -1;  v.kb_mid = -1;  v.ack_pre = 1'b0;  v.ack_mid = 1'b0;
    v.exp_mdr = exp_mdr;  v.exp_err = 1'b0;  v.exp_lat = exp_lat;
    v.exp_cs = exp_cs;  v.exp_stb = 0;
    return v;
  endfunction

  task automatic do_vec(input int idx, input vec_t v);
    int  cs0, we0, st0, er0;
    bit  got;
    sb_t e;
    if (v.kb_pre >= 0) begin
      KB_DATA = 8'(v.kb_pre); KB_STROBE = 1'b1;
      @(posedge CLK); #1 KB_STROBE = 1'b0;
    end
    if (v.ack_pre) begin
      DISP_ACK = 1'b1;
      @(posedge CLK); #1 DISP_ACK = 1'b0;
    end
    BUS_IN = v.addr; MAR_LD = 1'b1;
    @(posedge CLK); #1 MAR_LD = 1'b0;
    if (v.rw) begin
      BUS_IN = v.wdata; MDR_LD = 1'b1;
      @(posedge CLK); #1 MDR_LD = 1'b0;
    end
    ram_lat = v.ram_lat; ram_dead = v.dead; stale_ready = v.stale;
    cs0 = cs_total; we0 = we_total; st0 = stb_total; er0 = err_total;
    sb.push_back('{v.exp_mdr, v.exp_err, v.exp_lat, cyc});
    RW = v.rw; MEM_EN = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge CLK); #1;
      KB_STROBE = 1'b0; DISP_ACK = 1'b0; stale_ready = 1'b0;
      if (i == 1) begin
        if (v.kb_mid >= 0) begin KB_DATA = 8'(v.kb_mid); KB_STROBE = 1'b1; end
        if (v.ack_mid) DISP_ACK = 1'b1;
      end
      if (R) begin
        got = 1'b1;
        e = sb.pop_front();
        chk($sformatf("v%0d mdr", idx), 32'(MDR_OUT), 32'(e.mdr));
        chk($sformatf("v%0d err", idx), 32'(ERR), 32'(e.err));
        chk($sformatf("v%0d latency", idx), 32'(cyc - e.start), 32'(e.lat));
      end
    end
    KB_STROBE = 1'b0; DISP_ACK = 1'b0;
    if (!got) begin
      void'(sb.pop_front());
      checks++; errors++;
      $display("FAIL v%0d no R within 40 cycles", idx);
    end
    repeat (3) @(posedge CLK);
    #1 chk($sformatf("v%0d R held", idx), 32'(R), 32'd1);
    MEM_EN = 1'b0;
    @(posedge CLK); #1;
    chk($sformatf("v%0d R drop", idx), 32'(R), 32'd0);
    if (v.exp_stb > 0) disp_exp = v.wdata[7:0];
    chk($sformatf("v%0d cs cycles", idx), 32'(cs_total - cs0), 32'(v.exp_cs));
    chk($sformatf("v%0d we cycles", idx), 32'(we_total - we0), v.rw ? 32'(v.exp_cs) : 32'd0);
    chk($sformatf("v%0d disp strobes", idx), 32'(stb_total - st0), 32'(v.exp_stb));
    chk($sformatf("v%0d err pulses", idx), 32'(er_total_delta(er0)), 32'(v.exp_err));
    chk($sformatf("v%0d disp data", idx), 32'(DISP_DATA), 32'(disp_exp));
    if (v.exp_cs > 0) begin
      chk($sformatf("v%0d ram addr", idx), 32'(cs_addr), 32'(v.addr));
      if (v.rw) chk($sformatf("v%0d ram din", idx), 32'(cs_din), 32'(v.wdata));
    end
  endtask

  function automatic int er_total_delta(input int er0);
    return err_total - er0;
  endfunction

  initial begin
    vec_t v;
    RST = 1'b1; BUS_IN = '0; MAR_LD = 0; MDR_LD = 0; MEM_EN = 0; RW = 0;
    KB_DATA = '0; KB_STROBE = 0; DISP_ACK = 0; stale_ready = 0;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset R", 32'(R), 32'd0);
    chk("reset ERR", 32'(ERR), 32'd0);
    chk("reset CS", 32'(RAM_CS), 32'd0);
    chk("reset WE", 32'(RAM_WE), 32'd0);
    chk("reset DISP_STROBE", 32'(DISP_STROBE), 32'd0);
    chk("reset MDR", 32'(MDR_OUT), 32'd0);
    chk("reset MAR", 32'(RAM_ADDR), 32'd0);
    chk("reset DISP_DATA", 32'(DISP_DATA), 32'd0);
    @(negedge CLK) RST = 1'b0;

    tv.push_back(mk(16'hFE04, 0, 16'h0, 16'h8000, 2, 0));   // DSR ready out of reset
    tv.push_back(mk(16'hFE00, 0, 16'h0, 16'h0000, 2, 0));   // KBSR empty
    tv.push_back(mk(16'h3000, 1, 16'hABCD, 16'hABCD, 2, 1));
    tv.push_back(mk(16'h3000, 0, 16'h0, 16'hABCD, 3, 1));
    tv.push_back(mk(16'h3001, 1, 16'h1234, 16'h1234, 2, 1));
    v = mk(16'h3001, 0, 16'h0, 16'h1234, 5, 1); v.ram_lat = 2; tv.push_back(v);
    v = mk(16'h3000, 0, 16'h0, 16'h0000, 10, 1); v.dead = 1; v.exp_err = 1; tv.push_back(v);
    v = mk(16'h3000, 0, 16'h0, 16'h0000, 10, 1); v.dead = 1; v.stale = 1; v.exp_err = 1; tv.push_back(v);
    tv.push_back(mk(16'h3000, 0, 16'h0, 16'hABCD, 3, 1));
    v = mk(16'hFE00, 0, 16'h0, 16'h8000, 2, 0); v.kb_pre = 8'h41; tv.push_back(v);
    tv.push_back(mk(16'hFE02, 0, 16'h0, 16'h0041, 2, 0));
    tv.push_back(mk(16'hFE00, 0, 16'h0, 16'h0000, 2, 0));
    v = mk(16'hFE06, 1, 16'h0048, 16'h0048, 2, 0); v.exp_stb = 1; tv.push_back(v);
    tv.push_back(mk(16'hFE04, 0, 16'h0, 16'h0000, 2, 0));
    tv.push_back(mk(16'hFE06, 1, 16'h0049, 16'h0049, 2, 0)); // dropped, display busy
    v = mk(16'hFE04, 0, 16'h0, 16'h8000, 2, 0); v.ack_pre = 1; tv.push_back(v);
    tv.push_back(mk(16'hFE02, 1, 16'h0055, 16'h0055, 2, 0)); // non-DDR write ignored
    tv.push_back(mk(16'hFE08, 0, 16'h0, 16'h0000, 2, 0));
    tv.push_back(mk(16'hFE06, 0, 16'h0, 16'h0000, 2, 0));
    v = mk(16'hFE06, 1, 16'h0049, 16'h0049, 2, 0); v.ack_mid = 1; v.exp_stb = 1; tv.push_back(v);
    tv.push_back(mk(16'hFE04, 0, 16'h0, 16'h0000, 2, 0));   // write wins over coincident ack
    v = mk(16'hFE02, 0, 16'h0, 16'h0033, 2, 0); v.kb_pre = 8'h33; v.kb_mid = 8'h5A; tv.push_back(v);
    tv.push_back(mk(16'hFE00, 0, 16'h0, 16'h8000, 2, 0));
    tv.push_back(mk(16'hFE02, 0, 16'h0, 16'h005A, 2, 0));
    tv.push_back(mk(16'hFE00, 0, 16'h0, 16'h0000, 2, 0));
    tv.push_back(mk(16'hFDFF, 1, 16'h7777, 16'h7777, 2, 1)); // last RAM address below I/O page
    tv.push_back(mk(16'hFDFF, 0, 16'h0, 16'h7777, 3, 1));

    foreach (tv[i]) do_vec(i, tv[i]);

    // Reset asserted while a read sits in RD_WAIT
    BUS_IN = 16'h3000; MAR_LD = 1'b1;
    @(posedge CLK); #1 MAR_LD = 1'b0;
    ram_dead = 1'b1; RW = 1'b0; MEM_EN = 1'b1;
    repeat (4) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("rst mid R", 32'(R), 32'd0);
    chk("rst mid ERR", 32'(ERR), 32'd0);
    chk("rst mid CS", 32'(RAM_CS), 32'd0);
    chk("rst mid MDR", 32'(MDR_OUT), 32'd0);
    chk("rst mid MAR", 32'(RAM_ADDR), 32'd0);
    chk("rst mid DISP_DATA", 32'(DISP_DATA), 32'd0);
    MEM_EN = 1'b0; ram_dead = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    disp_exp = 8'h00;

    do_vec(100, mk(16'hFE04, 0, 16'h0, 16'h8000, 2, 0));
    do_vec(101, mk(16'h3000, 0, 16'h0, 16'hABCD, 3, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
